fetch_decode_latch: RTL and testbench
=====================================

Name: fetch_decode_latch

Overview:
Pipeline boundary register between the fetch stage and the decode stage. It captures the fetched PC and instruction whenever the instruction cache reports a hit. A 2-entry skid buffer absorbs one extra beat when decode stalls, and the block raises a registered back-pressure signal toward the PC. On flush (jump, branch or exception redirect) it drops all buffered instructions and presents a NOP bubble to decode. It also keeps a saturating bubble counter for performance debug.

Parameters:
ADDR_W, 32, width of PC values (matches `ADDR_SIZE)
INSTR_W, 32, width of instruction word
NOP_VALUE, 32'h0000_0000, instruction driven to decode when id_valid=0
CNT_W, 16, width of bubble counter

Ports:
clk  in  1  stage clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
fetch_valid  in  1  fetch beat valid (icache hit for current PC)
fetch_pc  in  ADDR_W  PC of the fetched instruction
fetch_instr  in  INSTR_W  instruction word from icache
flush  in  1  redirect taken (is_jump | is_branch | is_exception); discard everything
decode_stall  in  1  decode cannot consume this cycle
fetch_stall  out  1  registered back-pressure; PC must hold while 1
id_valid  out  1  id_pc / id_instr are a real instruction
id_pc  out  ADDR_W  PC presented to decode
id_instr  out  INSTR_W  instruction presented to decode (NOP_VALUE when invalid)
bubble_count  out  CNT_W  cycles since reset with id_valid=0, saturating

Behaviour:
- All state updates on the rising edge of clk. Priority each edge: reset, then flush, then normal operation.
- Reset (reset==0): state=EMPTY, id_valid=0, id_pc=0, id_instr=NOP_VALUE, skid cleared, fetch_stall=0, bubble_count=0.
- Handshake: acc = fetch_valid & ~fetch_stall; adv = ~decode_stall. When fetch_stall=1, fetch_pc/fetch_instr are ignored; the PC logic must re-present the same beat later.
- fetch_stall = (state==FULL). It is a pure function of registered state, with no combinational path from any input.
- States, with transitions on non-flush cycles:
  - EMPTY: acc -> ONE, out<=in. Otherwise stay EMPTY. decode_stall is ignored in EMPTY.
  - ONE: acc&adv -> ONE, out<=in. acc&~adv -> FULL, skid<=in, out held. ~acc&adv -> EMPTY. ~acc&~adv -> ONE, held.
  - FULL: adv -> ONE, out<=skid. ~adv -> FULL, all held. Input is never accepted in FULL.
- id_valid = (state != EMPTY). In EMPTY, id_instr=NOP_VALUE and id_pc holds its last value.
- Latency: an accepted beat appears on id_* the cycle after acceptance. There is no combinational input-to-output path.
- Flush: next state EMPTY, skid cleared, id_valid=0, id_instr=NOP_VALUE. The beat presented in the flush cycle is discarded even if fetch_valid=1. Flush overrides decode_stall. fetch_stall is 0 in the cycle after a flush.
- Ordering: beats reach decode strictly in acceptance order. The skid entry always precedes any later beat.
- bubble_count increments every non-reset cycle in which the registered id_valid=0, and saturates at 2^CNT_W-1 without wrapping.
- Reset asserted mid-operation behaves exactly like reset from power-up. Buffered entries are lost.

Test Plan:
- Stream: reset then release; fetch_valid=1 with PCs 0x0,0x4,0x8 and instructions 0x11,0x22,0x33, decode_stall=0 -> id_valid=1 from cycle 1; id_pc follows 0x0,0x4,0x8 one cycle late; fetch_stall always 0.
- Stall and skid: decode_stall=1 while out holds 0x4 and 0x8 is accepted -> fetch_stall=1 next cycle; 0xC is ignored; on release id_pc shows 0x4, 0x8, then 0xC after re-presentation; no beat lost or duplicated.
- Miss bubble: fetch_valid=0 for 3 cycles -> id_valid=0, id_instr=0x0 for 3 cycles; bubble_count increases by 3.
- Flush in FULL: state FULL (0x4 out, 0x8 skid), flush=1 with fetch_valid=1 at PC 0x40 -> next cycle id_valid=0 and fetch_stall=0; a subsequent 0x40 beat appears alone.
- Flush vs stall: flush=1 and decode_stall=1 in the same cycle -> flush wins and state becomes EMPTY.
- Reset mid-FULL: reset=0 for 1 cycle -> all outputs at reset values; bubble_count=0. CNT_W=4 saturation: 20 bubble cycles -> bubble_count=15.

Source files
------------

// File: rtl/fetch_decode_latch.sv
// Fetch/decode pipeline boundary register with a 2-entry skid buffer,
// registered back-pressure, flush-to-bubble and a saturating bubble counter.
module fetch_decode_latch #(
  parameter int unsigned               ADDR_W    = 32,
  parameter int unsigned               INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]        NOP_VALUE = '0,
  parameter int unsigned               CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_valid,
  input  logic [ADDR_W-1:0]  fetch_pc,
  input  logic [INSTR_W-1:0] fetch_instr,
  input  logic               flush,
  input  logic               decode_stall,
  output logic               fetch_stall,
  output logic               id_valid,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic [CNT_W-1:0]   bubble_count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]         state;
  logic [ADDR_W-1:0]  out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               acc;
  logic               adv;

  // Handshake and outputs derived purely from registered state (no input-to-output path).
  always_comb begin
    fetch_stall = (state == FULL);
    id_valid    = (state != EMPTY);
    id_pc       = out_pc;
    id_instr    = id_valid ? out_instr : NOP_VALUE;
    acc         = fetch_valid & ~fetch_stall;
    adv         = ~decode_stall;
  end

  // Occupancy FSM: output register plus one skid entry, flush drops both.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= EMPTY;
      out_pc     <= '0;
      out_instr  <= NOP_VALUE;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (flush) begin
      state      <= EMPTY;
      out_instr  <= NOP_VALUE;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state     <= ONE;
            out_pc    <= fetch_pc;
            out_instr <= fetch_instr;
          end
        end
        ONE: begin
          if (acc && adv) begin
            out_pc    <= fetch_pc;
            out_instr <= fetch_instr;
          end else if (acc) begin
            state      <= FULL;
            skid_pc    <= fetch_pc;
            skid_instr <= fetch_instr;
          end else if (adv) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (adv) begin
            state      <= ONE;
            out_pc     <= skid_pc;
            out_instr  <= skid_instr;
            skid_pc    <= '0;
            skid_instr <= '0;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Saturating count of cycles in which decode saw a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_count <= '0;
    end else if ((state == EMPTY) && (bubble_count != '1)) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_decode_latch.sv
// Self-checking bench for fetch_decode_latch: directed scenarios plus a
// randomized run, all checked against a queue-based occupancy model.
module tb_fetch_decode_latch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        flush;
  logic        decode_stall;
  logic        fetch_stall;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [15:0] bubble_count;

  logic        fs4;
  logic        iv4;
  logic [31:0] pc4;
  logic [31:0] in4;
  logic [3:0]  bc4_dut;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fetch_decode_latch dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .flush(flush), .decode_stall(decode_stall),
    .fetch_stall(fetch_stall), .id_valid(id_valid), .id_pc(id_pc),
    .id_instr(id_instr), .bubble_count(bubble_count)
  );

  fetch_decode_latch #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr), .flush(flush), .decode_stall(decode_stall),
    .fetch_stall(fs4), .id_valid(iv4), .id_pc(pc4),
    .id_instr(in4), .bubble_count(bc4_dut)
  );

  // Reference model: queue of accepted beats; head is what decode sees.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  beat_t       q[$];
  logic [31:0] last_pc = '0;
  int unsigned bc  = 0;
  int unsigned bc4 = 0;

  function automatic void model_step();
    beat_t b;
    bit    accept;
    if (!reset) begin
      q.delete();
      last_pc = '0;
      bc  = 0;
      bc4 = 0;
    end else begin
      if (q.size() == 0) begin
        if (bc  < 65535) bc++;
        if (bc4 < 15)    bc4++;
      end
      accept = fetch_valid && (q.size() < 2);
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() > 0 && !decode_stall) void'(q.pop_front());
        if (accept) begin
          b.pc    = fetch_pc;
          b.instr = fetch_instr;
          q.push_back(b);
        end
      end
      if (q.size() > 0) last_pc = q[0].pc;
    end
  endfunction

  function automatic logic [81:0] exp_vec();
    logic v;
    v = (q.size() > 0);
    return {(q.size() == 2), v, last_pc, (v ? q[0].instr : 32'h0), 16'(bc)};
  endfunction

  function automatic logic [81:0] obs_vec();
    return {fetch_stall, id_valid, id_pc, id_instr, bubble_count};
  endfunction

  task automatic cycle(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic fl, input logic ds, input logic rst_n);
    fetch_valid  = fv;
    fetch_pc     = pc;
    fetch_instr  = ins;
    flush        = fl;
    decode_stall = ds;
    reset        = rst_n;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 32'h0, 32'h0, 0, 0, 0);
    cycle(0, 32'h0, 32'h0, 0, 0, 0);
    checks++;
    if (obs_vec() !== {1'b0, 1'b0, 32'h0, 32'h0, 16'h0}) begin
      fails++;
      $display("FAIL reset_state got=%h want=%h", obs_vec(), {1'b0, 1'b0, 32'h0, 32'h0, 16'h0});
    end
    checks++;
    if (bc4_dut !== 4'h0) begin
      fails++;
      $display("FAIL reset_bc4 got=%0d want=0", bc4_dut);
    end
  endtask

  task automatic test_stream();
    logic [31:0] pcs[3];
    logic [31:0] ins[3];
    pcs = '{32'h0, 32'h4, 32'h8};
    ins = '{32'h11, 32'h22, 32'h33};
    for (int unsigned i = 0; i < 3; i++) begin
      cycle(1, pcs[i], ins[i], 0, 0, 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL stream_model[%0d] got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
      if ({fetch_stall, id_valid, id_pc, id_instr} !== {1'b0, 1'b1, pcs[i], ins[i]}) begin
        fails++;
        $display("FAIL stream_out[%0d] got=%h want=%h", i, {fetch_stall, id_valid, id_pc, id_instr},
                 {1'b0, 1'b1, pcs[i], ins[i]});
      end
    end
  endtask

  task automatic test_miss_bubble();
    logic [15:0] start;
    cycle(0, 32'h0, 32'h0, 0, 0, 1);
    start = bubble_count;
    for (int unsigned i = 0; i < 3; i++) begin
      cycle(0, 32'h0, 32'h0, 0, 0, 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL miss_model[%0d] got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    checks++;
    if ({id_valid, id_instr} !== {1'b0, 32'h0}) begin
      fails++;
      $display("FAIL miss_nop got=%h want=0", {id_valid, id_instr});
    end
    checks++;
    if (bubble_count !== start + 16'd3) begin
      fails++;
      $display("FAIL miss_count got=%0d want=%0d", bubble_count, start + 16'd3);
    end
  endtask

  task automatic test_stall_skid();
    logic [31:0] want_pc[5];
    logic [31:0] pres[5];
    logic        stall[5];
    want_pc = '{32'h4, 32'h4, 32'h4, 32'h8, 32'hC};
    pres    = '{32'h4, 32'h8, 32'hC, 32'hC, 32'hC};
    stall   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    cycle(0, 32'h0, 32'h0, 0, 0, 0);
    for (int unsigned i = 0; i < 5; i++) begin
      cycle(1, pres[i], pres[i] + 32'h100, 0, (i == 1 || i == 2), 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL skid_model[%0d] got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
      if ({fetch_stall, id_pc, id_instr} !== {stall[i], want_pc[i], want_pc[i] + 32'h100}) begin
        fails++;
        $display("FAIL skid_out[%0d] got=%h want=%h", i, {fetch_stall, id_pc, id_instr},
                 {stall[i], want_pc[i], want_pc[i] + 32'h100});
      end
    end
  endtask

  task automatic fill_full();
    cycle(0, 32'h0, 32'h0, 0, 0, 0);
    cycle(1, 32'h4, 32'h44, 0, 0, 1);
    cycle(1, 32'h8, 32'h88, 0, 1, 1);
    checks++;
    if ({fetch_stall, id_pc} !== {1'b1, 32'h4}) begin
      fails++;
      $display("FAIL fill_full got=%h want=%h", {fetch_stall, id_pc}, {1'b1, 32'h4});
    end
  endtask

  task automatic test_flush_full();
    fill_full();
    cycle(1, 32'h40, 32'h4040, 1, 0, 1);
    checks++;
    if ({fetch_stall, id_valid, id_instr} !== {1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL flush_full got=%h want=%h", {fetch_stall, id_valid, id_instr}, {1'b0, 1'b0, 32'h0});
    end
    cycle(1, 32'h40, 32'h4040, 0, 0, 1);
    checks++;
    if ({id_valid, id_pc, id_instr} !== {1'b1, 32'h40, 32'h4040}) begin
      fails++;
      $display("FAIL flush_refetch got=%h want=%h", {id_valid, id_pc, id_instr}, {1'b1, 32'h40, 32'h4040});
    end
    cycle(0, 32'h0, 32'h0, 0, 0, 1);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL flush_alone got=%h want=%h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_flush_vs_stall();
    cycle(1, 32'h80, 32'h8080, 0, 0, 1);
    cycle(1, 32'h84, 32'h8484, 1, 1, 1);
    checks++;
    if ({fetch_stall, id_valid, id_instr} !== {1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL flush_vs_stall got=%h want=%h", {fetch_stall, id_valid, id_instr}, {1'b0, 1'b0, 32'h0});
    end
  endtask

  task automatic test_reset_mid_full();
    fill_full();
    cycle(1, 32'hC, 32'hCC, 0, 1, 0);
    checks++;
    if (obs_vec() !== {1'b0, 1'b0, 32'h0, 32'h0, 16'h0}) begin
      fails++;
      $display("FAIL reset_mid got=%h want=%h", obs_vec(), {1'b0, 1'b0, 32'h0, 32'h0, 16'h0});
    end
  endtask

  task automatic test_saturation();
    cycle(0, 32'h0, 32'h0, 0, 0, 0);
    for (int unsigned i = 0; i < 20; i++) begin
      cycle(0, 32'h0, 32'h0, 0, 0, 1);
      checks++;
      if (bc4_dut !== 4'(bc4)) begin
        fails++;
        $display("FAIL sat_model[%0d] got=%0d want=%0d", i, bc4_dut, bc4);
      end
    end
    checks++;
    if (bc4_dut !== 4'd15) begin
      fails++;
      $display("FAIL sat_final got=%0d want=15", bc4_dut);
    end
    checks++;
    if (bubble_count !== 16'd20) begin
      fails++;
      $display("FAIL sat_wide got=%0d want=20", bubble_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    logic [31:0] ins;
    logic        fv, fl, ds, rst_n;
    bit          take;
    pc  = 32'h1000;
    ins = $urandom;
    cycle(0, 32'h0, 32'h0, 0, 0, 0);
    for (int unsigned i = 0; i < 400; i++) begin
      fv    = ($urandom_range(0, 9) < 7);
      ds    = ($urandom_range(0, 9) < 4);
      fl    = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      take  = fv && (q.size() < 2);
      cycle(fv, pc, ins, fl, ds, rst_n);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random[%0d] got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
      if (bc4_dut !== 4'(bc4)) begin
        fails++;
        $display("FAIL random_bc4[%0d] got=%0d want=%0d", i, bc4_dut, bc4);
      end
      if (fl || !rst_n) begin
        pc  = {$urandom_range(0, 65535), 2'b00};
        ins = $urandom;
      end else if (take) begin
        pc  = pc + 32'h4;
        ins = $urandom;
      end
    end
  endtask

  initial begin
    fetch_valid  = 1'b0;
    fetch_pc     = '0;
    fetch_instr  = '0;
    flush        = 1'b0;
    decode_stall = 1'b0;
    reset        = 1'b0;
    test_reset();
    test_stream();
    test_miss_bubble();
    test_stall_skid();
    test_flush_full();
    test_flush_vs_stall();
    test_reset_mid_full();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
